// File: rtl/sync_debounce_if.sv
// -----------------------------------------------------------------------------
// sync_debounce_if
//   Bundles the sample qualifier, the synchronized raw levels and the
//   debounced results of sync_debounce into one interface.
//
//   Signals
//     tick      1          sample qualifier (1 = count this clk)
//     i         DATAWIDTH  synchronized raw levels
//     o         DATAWIDTH  debounced levels
//     rise      DATAWIDTH  1-clk pulse, o went 0->1
//     fall      DATAWIDTH  1-clk pulse, o went 1->0
//     any_edge  1          OR of all rise|fall bits, same cycle
//
//   Modports
//     master  the side that supplies tick/i and consumes the results
//     slave   the debouncer itself
// -----------------------------------------------------------------------------
interface sync_debounce_if #(
  parameter int DATAWIDTH = 1
);

  logic                 tick;
  logic [DATAWIDTH-1:0] i;
  logic [DATAWIDTH-1:0] o;
  logic [DATAWIDTH-1:0] rise;
  logic [DATAWIDTH-1:0] fall;
  logic                 any_edge;

  modport master (
    output tick,
    output i,
    input  o,
    input  rise,
    input  fall,
    input  any_edge
  );

  modport slave (
    input  tick,
    input  i,
    output o,
    output rise,
    output fall,
    output any_edge
  );

endinterface

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
//   Multi-channel debouncer with edge detection. Takes pin levels that are
//   already synchronized into the clk domain and produces a clean level per
//   channel plus registered one-cycle rise/fall pulses and a combined
//   any_edge flag. A new level must be seen on DEBOUNCE consecutive ticked
//   samples before it is accepted; cycles with tick low neither advance nor
//   clear a pending run, so an external prescaler stretches the window
//   without widening the counters.
//
//   Parameters
//     DATAWIDTH  number of independent channels
//     DEBOUNCE   qualifying samples a new level must hold (>= 1)
//     CNTW       per-channel counter width (DEBOUNCE-1 must fit)
//     RESET_VAL  reset value of o, normally the pins' idle level
//
//   Ports
//     clk      clock
//     reset_l  synchronous active-low reset
//     bus      sync_debounce_if.slave: tick, i in; o, rise, fall, any_edge out
// -----------------------------------------------------------------------------
module sync_debounce #(
  parameter int                   DATAWIDTH = 1,
  parameter int                   DEBOUNCE  = 4,
  parameter int                   CNTW      = 8,
  parameter logic [DATAWIDTH-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset_l,
  sync_debounce_if.slave bus
);

  // Terminal count: the DEBOUNCE-th consecutive ticked mismatch is the one
  // that sees the counter already sitting at DEBOUNCE-1.
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE - 1);

  logic [DATAWIDTH-1:0] o_reg;
  logic [DATAWIDTH-1:0] o_next;
  logic [DATAWIDTH-1:0] rise_reg;
  logic [DATAWIDTH-1:0] rise_next;
  logic [DATAWIDTH-1:0] fall_reg;
  logic [DATAWIDTH-1:0] fall_next;
  logic                 any_edge_reg;
  logic                 any_edge_next;

  // ---------------------------------------------------------------------------
  // Per-channel qualification counter and next-state logic
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DATAWIDTH; gi++) begin : g_ch
      logic [CNTW-1:0] cnt_reg;
      logic [CNTW-1:0] cnt_next;
      logic            ch_o_next;
      logic            ch_rise_next;
      logic            ch_fall_next;

      always_comb begin
        cnt_next     = cnt_reg;
        ch_o_next    = o_reg[gi];
        ch_rise_next = 1'b0;
        ch_fall_next = 1'b0;

        if (bus.i[gi] == o_reg[gi]) begin
          // Input agrees with the accepted level: any pending run is broken,
          // regardless of tick.
          cnt_next = '0;
        end else if (bus.tick) begin
          if (cnt_reg == CNT_LAST) begin
            // Run complete: accept the new level and flag its direction.
            ch_o_next    = bus.i[gi];
            cnt_next     = '0;
            ch_rise_next = bus.i[gi];
            ch_fall_next = ~bus.i[gi];
          end else begin
            cnt_next = cnt_reg + CNTW'(1);
          end
        end
        // Mismatch without tick: counter and level simply hold.
      end

      always_ff @(posedge clk) begin
        if (!reset_l) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign o_next[gi]    = ch_o_next;
      assign rise_next[gi] = ch_rise_next;
      assign fall_next[gi] = ch_fall_next;
    end
  endgenerate

  // any_edge is built from the next-state pulses so that, once registered,
  // it lines up exactly with rise/fall instead of trailing them by a cycle.
  assign any_edge_next = |(rise_next | fall_next);

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      o_reg        <= RESET_VAL;
      rise_reg     <= '0;
      fall_reg     <= '0;
      any_edge_reg <= 1'b0;
    end else begin
      o_reg        <= o_next;
      rise_reg     <= rise_next;
      fall_reg     <= fall_next;
      any_edge_reg <= any_edge_next;
    end
  end

  assign bus.o        = o_reg;
  assign bus.rise     = rise_reg;
  assign bus.fall     = fall_reg;
  assign bus.any_edge = any_edge_reg;

endmodule

// File: tb/tb_sync_debounce.sv
// -----------------------------------------------------------------------------
// tb_sync_debounce
//   Directed bench for sync_debounce. dut_a: 4 channels, DEBOUNCE=4,
//   RESET_VAL=0. dut_b: 1 channel, DEBOUNCE=1, RESET_VAL=1. Inputs are
//   changed and outputs sampled 1 time unit after each rising clk edge.
// -----------------------------------------------------------------------------
module tb_sync_debounce;

  logic clk = 1'b0;
  logic reset_l;

  always #5 clk = ~clk;

  sync_debounce_if #(.DATAWIDTH(4)) bus_a ();
  sync_debounce_if #(.DATAWIDTH(1)) bus_b ();

  sync_debounce #(
    .DATAWIDTH(4),
    .DEBOUNCE (4),
    .CNTW     (8),
    .RESET_VAL(4'b0000)
  ) dut_a (
    .clk    (clk),
    .reset_l(reset_l),
    .bus    (bus_a)
  );

  sync_debounce #(
    .DATAWIDTH(1),
    .DEBOUNCE (1),
    .CNTW     (4),
    .RESET_VAL(1'b1)
  ) dut_b (
    .clk    (clk),
    .reset_l(reset_l),
    .bus    (bus_b)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    reset_l    = 1'b0;
    bus_a.tick = 1'b1;
    bus_a.i    = 4'b0000;
    bus_b.tick = 1'b1;
    bus_b.i    = 1'b0;
    cyc();
    cyc();
    check("rst_a_o",    32'(bus_a.o),        32'h0);
    check("rst_a_rise", 32'(bus_a.rise),     32'h0);
    check("rst_a_fall", 32'(bus_a.fall),     32'h0);
    check("rst_a_any",  32'(bus_a.any_edge), 32'h0);
    check("rst_b_o",    32'(bus_b.o),        32'h1);
    check("rst_b_any",  32'(bus_b.any_edge), 32'h0);

    // ---------------- 1: basic rise, latency DEBOUNCE ----------------
    bus_b.i = 1'b1;
    reset_l = 1'b1;
    bus_a.i = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      cyc();
      check($sformatf("t1_o_c%0d", c),    32'(bus_a.o),        (c >= 3) ? 32'h1 : 32'h0);
      check($sformatf("t1_rise_c%0d", c), 32'(bus_a.rise),     (c == 3) ? 32'h1 : 32'h0);
      check($sformatf("t1_fall_c%0d", c), 32'(bus_a.fall),     32'h0);
      check($sformatf("t1_any_c%0d", c),  32'(bus_a.any_edge), (c == 3) ? 32'h1 : 32'h0);
    end

    // ---------------- 2: glitch on ch1, then full window ----------------
    bus_a.i = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      cyc();
      check($sformatf("t2_glitch_o_c%0d", c),    32'(bus_a.o),    32'h1);
      check($sformatf("t2_glitch_rise_c%0d", c), 32'(bus_a.rise), 32'h0);
    end
    bus_a.i = 4'b0001;
    cyc();
    check("t2_back_o",   32'(bus_a.o),        32'h1);
    check("t2_back_any", 32'(bus_a.any_edge), 32'h0);
    // Counter must have restarted: the new run needs all 4 samples again.
    bus_a.i = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      cyc();
      check($sformatf("t2_rerun_o_c%0d", c),    32'(bus_a.o),    (c == 3) ? 32'h3 : 32'h1);
      check($sformatf("t2_rerun_rise_c%0d", c), 32'(bus_a.rise), (c == 3) ? 32'h2 : 32'h0);
    end

    // ---------------- 3: tick every 4th clk on ch2 ----------------
    bus_a.i = 4'b0111;
    for (int c = 0; c < 17; c++) begin
      bus_a.tick = ((c % 4) == 3);
      cyc();
      check($sformatf("t3_o_c%0d", c),    32'(bus_a.o),    (c >= 15) ? 32'h7 : 32'h3);
      check($sformatf("t3_rise_c%0d", c), 32'(bus_a.rise), (c == 15) ? 32'h4 : 32'h0);
    end
    bus_a.tick = 1'b1;

    // ---------------- 4a: ch0+ch2 fall together ----------------
    bus_a.i = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      cyc();
      check($sformatf("t4a_o_c%0d", c),    32'(bus_a.o),        (c == 3) ? 32'h2 : 32'h7);
      check($sformatf("t4a_fall_c%0d", c), 32'(bus_a.fall),     (c == 3) ? 32'h5 : 32'h0);
      check($sformatf("t4a_any_c%0d", c),  32'(bus_a.any_edge), (c == 3) ? 32'h1 : 32'h0);
    end

    // ---------------- 4: ch0+ch2 rise, ch1 falls 2 clks later ----------------
    for (int c = 0; c < 7; c++) begin
      bus_a.i = (c < 2) ? 4'b0111 : 4'b0101;
      cyc();
      check($sformatf("t4_o_c%0d", c), 32'(bus_a.o),
            (c < 3) ? 32'h2 : ((c < 5) ? 32'h7 : 32'h5));
      check($sformatf("t4_rise_c%0d", c), 32'(bus_a.rise),     (c == 3) ? 32'h5 : 32'h0);
      check($sformatf("t4_fall_c%0d", c), 32'(bus_a.fall),     (c == 5) ? 32'h2 : 32'h0);
      check($sformatf("t4_any_c%0d", c),  32'(bus_a.any_edge), (c == 3 || c == 5) ? 32'h1 : 32'h0);
    end

    // ---------------- 5: reset mid-count ----------------
    reset_l = 1'b0;
    bus_a.i = 4'b0000;
    cyc();
    check("t5_rst_o", 32'(bus_a.o), 32'h0);
    reset_l = 1'b1;
    bus_a.i = 4'b0001;
    cyc();
    cyc();
    check("t5_pending_o", 32'(bus_a.o), 32'h0);
    reset_l = 1'b0;
    cyc();
    check("t5_midrst_o",    32'(bus_a.o),    32'h0);
    check("t5_midrst_rise", 32'(bus_a.rise), 32'h0);
    reset_l = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      check($sformatf("t5_o_c%0d", c),    32'(bus_a.o),    (c == 3) ? 32'h1 : 32'h0);
      check($sformatf("t5_rise_c%0d", c), 32'(bus_a.rise), (c == 3) ? 32'h1 : 32'h0);
    end

    // ---------------- 6: DEBOUNCE=1 tracking; ch3 toggling never qualifies ----------------
    for (int c = 0; c < 6; c++) begin
      bus_b.i = 1'((c % 2));
      bus_a.i = ((c % 2) == 1) ? 4'b1001 : 4'b0001;
      cyc();
      check($sformatf("t6_b_o_c%0d", c),    32'(bus_b.o),        32'(c % 2));
      check($sformatf("t6_b_rise_c%0d", c), 32'(bus_b.rise),     32'(c % 2));
      check($sformatf("t6_b_fall_c%0d", c), 32'(bus_b.fall),     32'(1 - (c % 2)));
      check($sformatf("t6_b_any_c%0d", c),  32'(bus_b.any_edge), 32'h1);
      check($sformatf("t6_a_o_c%0d", c),    32'(bus_a.o),        32'h1);
      check($sformatf("t6_a_any_c%0d", c),  32'(bus_a.any_edge), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
